// File: rtl/counter_acc_pkg.sv
// Shared types and default widths for the counter_accumulator block.
package counter_acc_pkg;

    localparam int SUM_W  = 16;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 48;

    typedef enum logic [0:0] {
        ACCUM      = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/counter_acc_lane.sv
// One accumulation lane: zero-extends the input, adds it on an accepted beat
// and clears when the frame closes. `total` is the running sum including the
// current beat, so a closing beat is already part of what gets latched.
// With COUNTER_ACC_SATURATE_EN defined the lane clamps at all-ones and keeps
// a sticky per-frame overflow flag; otherwise it wraps and reports no overflow.
module counter_acc_lane #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add,
    input  logic             clear,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] total,
    output logic             ovf_total
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] addend;

    // Only an accepted beat contributes to the running total.
    always_comb addend = add ? ACC_W'(din) : '0;

`ifdef COUNTER_ACC_SATURATE_EN
    logic [ACC_W:0] raw;
    logic           ovf;

    // Carry out of the wide add means the lane must clamp.
    always_comb begin
        raw       = {1'b0, acc} + {1'b0, addend};
        total     = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
        ovf_total = ovf | raw[ACC_W];
    end

    // Sticky saturation flag, cleared with the frame.
    always_ff @(posedge clk) begin
        if (rst || clear) ovf <= 1'b0;
        else if (add)     ovf <= ovf_total;
    end
`else
    // Plain modulo-2^ACC_W accumulation.
    always_comb begin
        total     = acc + addend;
        ovf_total = 1'b0;
    end
`endif

    // Accumulator register; a closing beat leaves the lane empty.
    always_ff @(posedge clk) begin
        if (rst || clear) acc <= '0;
        else if (add)     acc <= total;
    end

endmodule

// File: rtl/counter_accumulator.sv
// Frames the sum/product beat stream into FRAME_LEN-beat totals and presents
// each closed frame on a single-entry valid/ready result register.
// Optional saturating lanes: define COUNTER_ACC_SATURATE_EN.
//
//  state      | meaning
//  -----------+--------------------------------------------------------------
//  ACCUM      | accepting beats; closes on the last beat or on flush
//  FLUSH_WAIT | flush seen with a partial frame but result busy; input stalled
module counter_accumulator #(
    parameter  int SUM_W     = counter_acc_pkg::SUM_W,
    parameter  int PROD_W    = counter_acc_pkg::PROD_W,
    parameter  int ACC_W     = counter_acc_pkg::ACC_W,
    parameter  int FRAME_LEN = 16,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  sum,
    input  logic [PROD_W-1:0] product,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum_acc,
    output logic [ACC_W-1:0]  out_prod_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    import counter_acc_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             slot_free;
    logic             close;
    logic [ACC_W-1:0] sum_total;
    logic [ACC_W-1:0] prod_total;
    logic             sum_ovf;
    logic             prod_ovf;

    // Stall only when the last beat would need a result slot that is still taken.
    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = 1'b0;
        if (!rst && state == ACCUM)
            in_ready = !(count == LAST && out_valid && !out_ready);
    end

    assign accept = in_valid && in_ready;

    // Next state and frame-close decision.
    always_comb begin
        state_next = state;
        close      = 1'b0;
        case (state)
            ACCUM: begin
                if (accept && count == LAST) begin
                    close = 1'b1;
                end else if (flush && (count != '0 || accept)) begin
                    if (slot_free) close = 1'b1;
                    else           state_next = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (slot_free) begin
                    close      = 1'b1;
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    // Beat counter for the frame in progress.
    always_ff @(posedge clk) begin
        if (rst || close) count <= '0;
        else if (accept)  count <= count + 1'b1;
    end

    counter_acc_lane #(.IN_W(SUM_W), .ACC_W(ACC_W)) u_sum_lane (
        .clk       (clk),
        .rst       (rst),
        .add       (accept),
        .clear     (close),
        .din       (sum),
        .total     (sum_total),
        .ovf_total (sum_ovf)
    );

    counter_acc_lane #(.IN_W(PROD_W), .ACC_W(ACC_W)) u_prod_lane (
        .clk       (clk),
        .rst       (rst),
        .add       (accept),
        .clear     (close),
        .din       (product),
        .total     (prod_total),
        .ovf_total (prod_ovf)
    );

    // Result register: load on close (also when the old result leaves the same cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_sum_acc  <= '0;
            out_prod_acc <= '0;
            out_count    <= '0;
            out_ovf      <= 1'b0;
        end else if (close) begin
            out_valid    <= 1'b1;
            out_sum_acc  <= sum_total;
            out_prod_acc <= prod_total;
            out_count    <= count + CNT_W'(accept);
            out_ovf      <= sum_ovf | prod_ovf;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: doc/counter_accumulator.md
# counter_accumulator

Downstream stage for the registered sum/product counter. It consumes the counter's `sum` and `product` stream, qualified by a valid strobe, and accumulates frames of `FRAME_LEN` beats into wide totals. Each completed or flushed frame is presented on a single-entry valid/ready output register. The block back-pressures upstream only when a frame must close while the previous result has not yet been taken.

## Interface
- `SUM_W`, 16, width of the incoming `sum`.
- `PROD_W`, 32, width of the incoming `product`.
- `ACC_W`, 48, accumulator and result width; must be ≥ `PROD_W`.
- `FRAME_LEN`, 16, beats per frame; must be ≥ 1.
- `CNT_W`, derived localparam, $clog2(FRAME_LEN+1).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  beat present on `sum`/`product`.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `sum`  in  SUM_W  unsigned operand sum from the counter.
- `product`  in  PROD_W  unsigned operand product from the counter.
- `flush`  in  1  level request to close the current partial frame.
- `out_valid`  out  1  result register holds an unconsumed frame.
- `out_ready`  in  1  consumer takes the result when `out_valid && out_ready`.
- `out_sum_acc`  out  ACC_W  frame total of `sum`.
- `out_prod_acc`  out  ACC_W  frame total of `product`.
- `out_count`  out  CNT_W  beats in the frame (1..FRAME_LEN).
- `out_ovf`  out  1  a lane saturated during this frame.

## Operation
- **Inputs:** unsigned; zero-extended to `ACC_W` before addition.
- **Accepted beat:** `acc_sum += sum`, `acc_prod += product`, `count++`.
- **Closing condition:** a frame closes when either holds:
  - the accepted beat is beat `FRAME_LEN` (`count == FRAME_LEN-1`), or
  - `flush` is high with `count > 0` or an accepted beat in the same cycle.
- **Close action:**
  - Load the result registers with the totals including the closing beat.
  - Set `out_valid`.
  - Clear accumulators, `count` and the per-frame overflow flag.
- **Emit gating:** a close happens only if the result register is free, i.e. `!out_valid || out_ready`.
- **FSM:**
  - `ACCUM`: `in_ready = !(count == FRAME_LEN-1 && out_valid && !out_ready)`.
  - `ACCUM → FLUSH_WAIT`: `flush` asserted, `count > 0`, result register occupied.
  - `FLUSH_WAIT`: `in_ready = 0`. Leave for `ACCUM` when the register frees; the partial frame closes in that same cycle.
- **`flush` edge cases:**
  - `flush` with `count == 0` and no accepted beat is ignored.
  - `flush` held continuously closes one frame per free slot. It never emits an empty frame.
- **Simultaneous events:**
  - Same-cycle consume and close: the old result leaves and the new one loads; `out_valid` stays 1.
  - `flush` on the `FRAME_LEN`-th beat: a single full frame closes, `out_count = FRAME_LEN`.

## Timing
- **Reset values:**
  - `out_valid` = 0.
  - `out_sum_acc`, `out_prod_acc`, `out_count`, `out_ovf` = 0.
  - Accumulators and `count` = 0; state = `ACCUM`.
  - `in_ready` = 0 while `rst` is high, 1 in the first cycle after.
- **Latency:** closing beat accepted at edge N → `out_valid` high after edge N (visible in cycle N+1).
- **Throughput:** one beat per cycle, with no bubble between frames while `out_ready` stays high.
- **Stability:** result outputs are stable while `out_valid && !out_ready`.
- **`in_ready` path:** combinational from `out_ready`; there is no path from `in_valid` to `in_ready`.
- **Reset mid-frame:** discards the partial frame and any pending result.

## Configuration
- **Macro:** `COUNTER_ACC_SATURATE_EN`.
- **Defined:**
  - Each lane clamps at 2^ACC_W−1 instead of wrapping.
  - `out_ovf` reports a sticky per-frame saturation flag.
- **Undefined:**
  - Lanes wrap modulo 2^ACC_W.
  - `out_ovf` is tied to 0.

## Structure
- **Package `counter_acc_pkg`:**
  - state enum {`ACCUM`, `FLUSH_WAIT`}.
  - default width constants `SUM_W`, `PROD_W`, `ACC_W`.
- **Sub-module `counter_acc_lane`:**
  - Parameterised input width, `ACC_W` accumulator.
  - Add, clear-on-close and (under the macro) saturation with sticky flag.
  - Instantiated twice: sum lane and product lane.
- **Top level:** count, FSM, handshakes and the result register.

## Test plan
- **Basic frame:** `FRAME_LEN=4`, `out_ready=1`; beats sum = 1,2,3,4 and product = 10,20,30,40 on consecutive cycles → one cycle after beat 4, `out_valid=1`, `out_sum_acc=10`, `out_prod_acc=100`, `out_count=4`, `out_ovf=0`.
- **Back-pressure:** `out_ready=0` after frame 1; stream 8 more beats of (1,1) → `in_ready` drops on beat 4 of frame 2 and stays 0. Raise `out_ready` → frame 1 consumed, frame 2 (4,4,count 4) loads in the same cycle.
- **Flush:** 3 beats of (2,5) then `flush` pulse → `out_count=3`, `out_sum_acc=6`, `out_prod_acc=15`. A further `flush` with `count=0` produces no output.
- **Flush wait:** flush while the result is occupied → state `FLUSH_WAIT` and `in_ready=0`. Partial frame emitted in the cycle `out_ready` rises.
- **Overflow:** `ACC_W=32`, two beats with `product=0xFFFFFFFF`, `FRAME_LEN=2`:
  - With the macro → `out_prod_acc=0xFFFFFFFF`, `out_ovf=1`.
  - Without the macro → `0xFFFFFFFE`, `out_ovf=0`.
- **Reset mid-frame:** assert `rst` after 2 of 4 beats, then send 4 beats of (1,1) → no output for the partial frame; next result is sum 4, product 4, count 4.
